// File: rtl/counter_bank_pkg.sv
// Shared constants and elaboration helpers for the multi-channel counter bank.
package counter_bank_pkg;

  localparam int unsigned MAX_CH = 16;

  // Prescaler bit that clocks channel i.
  function automatic int unsigned tap_index(input int unsigned i,
                                            input int unsigned base,
                                            input int unsigned step);
    return base + i * step;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_counter.sv
// One up/down counter channel with synchronous clear, snapshot register and wrap pulse.
module chan_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic             dir,
  input  logic             cap,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] snap,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      snap <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      // Snapshot takes the value before this edge's update.
      if (cap) snap <= cnt;
      if (clr) begin
        cnt <= '0;
      end else if (tick) begin
        if (dir) begin
          cnt  <= cnt + CNT_W'(1);
          wrap <= (cnt == {CNT_W{1'b1}});
        end else begin
          cnt  <= cnt - CNT_W'(1);
          wrap <= (cnt == '0);
        end
      end
    end
  end

endmodule

// File: rtl/counter_bank_mux.sv
// Counter bank top: shared prescaler, per-channel tick edge detect, freeze snapshot and
// registered lamp mux.
module counter_bank_mux
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESC_W  = 26,
  parameter int unsigned TAP_BASE = 10,
  parameter int unsigned TAP_STEP = 5,
  parameter int unsigned SEL_W    = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              dir,
  input  logic [NUM_CH-1:0] clr,
  input  logic [SEL_W-1:0]  sel,
  input  logic              enable,
  input  logic              freeze,
  output logic [CNT_W-1:0]  lamps,
  output logic [NUM_CH-1:0] wrap
);

  if (TAP_BASE + (NUM_CH - 1) * TAP_STEP >= PRESC_W) begin : g_bad_tap
    $error("counter_bank_mux: highest tap index exceeds prescaler width");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("counter_bank_mux: CNT_W must be at least 1");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("counter_bank_mux: NUM_CH out of range");
  end

  logic [PRESC_W-1:0] presc;
  logic [NUM_CH-1:0]  tap_bits;
  logic [NUM_CH-1:0]  hist;
  logic [NUM_CH-1:0]  tick;
  logic               freeze_d;
  logic               cap;
  logic [CNT_W-1:0]   cnt_a  [NUM_CH];
  logic [CNT_W-1:0]   snap_a [NUM_CH];
  logic [CNT_W-1:0]   src;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      hist     <= '0;
      freeze_d <= 1'b0;
    end else begin
      freeze_d <= freeze;
      if (run) begin
        presc <= presc + PRESC_W'(1);
        hist  <= tap_bits;
      end
    end
  end

  // Rising edge of each tap; gated by run so a stalled prescaler cannot re-tick.
  assign tick = {NUM_CH{run}} & tap_bits & ~hist;
  assign cap  = freeze & ~freeze_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned TAP = tap_index(i, TAP_BASE, TAP_STEP);
    assign tap_bits[i] = presc[TAP];

    chan_counter #(.CNT_W(CNT_W)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr[i]),
      .tick (tick[i]),
      .dir  (dir),
      .cap  (cap),
      .cnt  (cnt_a[i]),
      .snap (snap_a[i]),
      .wrap (wrap[i])
    );
  end

  // Out-of-range sel matches no channel and leaves the source at zero.
  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) src = freeze ? snap_a[i] : cnt_a[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lamps <= '0;
    else     lamps <= enable ? src : '0;
  end

endmodule

// File: tb/tb_counter_bank_mux.sv
// Randomized bench for counter_bank_mux: a 4-channel and a 3-channel instance share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_counter_bank_mux;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PRESC_W  = 8;
  localparam int unsigned TAP_BASE = 1;
  localparam int unsigned TAP_STEP = 1;
  localparam int          MASK     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, run, dir, enable, freeze;
  logic [3:0]       clr;
  logic [1:0]       sel;
  logic [CNT_W-1:0] lamps4, lamps3;
  logic [3:0]       wrap4;
  logic [2:0]       wrap3;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = 4-channel instance, 1 = 3-channel instance.
  int nch [2] = '{4, 3};
  int p, fd;
  int m_cnt  [2][4];
  int m_snap [2][4];
  int m_wrap [2][4];
  int m_lamps[2];

  always #5 clk = ~clk;

  counter_bank_mux #(
    .NUM_CH(4), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .TAP_BASE(TAP_BASE), .TAP_STEP(TAP_STEP)
  ) dut4 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .clr(clr), .sel(sel),
    .enable(enable), .freeze(freeze), .lamps(lamps4), .wrap(wrap4)
  );

  counter_bank_mux #(
    .NUM_CH(3), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .TAP_BASE(TAP_BASE), .TAP_STEP(TAP_STEP)
  ) dut3 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .clr(clr[2:0]), .sel(sel),
    .enable(enable), .freeze(freeze), .lamps(lamps3), .wrap(wrap3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel i ticks once per 2^(tap+1) run edges, when the prescaler count sits at 2^tap mod that.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_lamps[k] = 0;
        for (int i = 0; i < 4; i++) begin
          m_cnt[k][i] = 0; m_snap[k][i] = 0; m_wrap[k][i] = 0;
        end
      end else begin
        int src;
        src = 0;
        if (int'(sel) < nch[k]) src = freeze ? m_snap[k][sel] : m_cnt[k][sel];
        m_lamps[k] = enable ? src : 0;
        for (int i = 0; i < nch[k]; i++) begin
          int tap;
          bit tk;
          tap = TAP_BASE + i * TAP_STEP;
          tk  = run && ((p % (1 << (tap + 1))) == (1 << tap));
          if (freeze && !fd) m_snap[k][i] = m_cnt[k][i];
          m_wrap[k][i] = 0;
          if (clr[i]) begin
            m_cnt[k][i] = 0;
          end else if (tk) begin
            if (dir) begin
              m_wrap[k][i] = (m_cnt[k][i] == MASK);
              m_cnt[k][i]  = (m_cnt[k][i] + 1) & MASK;
            end else begin
              m_wrap[k][i] = (m_cnt[k][i] == 0);
              m_cnt[k][i]  = (m_cnt[k][i] + MASK) & MASK;
            end
          end
        end
      end
    end
    if (rst) begin
      p = 0; fd = 0;
    end else begin
      fd = freeze;
      if (run) p = (p + 1) % (1 << PRESC_W);
    end
  endtask

  task automatic step();
    int ew4, ew3;
    @(posedge clk);
    model_step();
    #1;
    ew4 = 0; ew3 = 0;
    for (int i = 0; i < 4; i++) ew4 |= m_wrap[0][i] << i;
    for (int i = 0; i < 3; i++) ew3 |= m_wrap[1][i] << i;
    check_eq("lamps4", 32'(lamps4), m_lamps[0]);
    check_eq("lamps3", 32'(lamps3), m_lamps[1]);
    check_eq("wrap4",  32'(wrap4),  ew4);
    check_eq("wrap3",  32'(wrap3),  ew3);
  endtask

  task automatic randomize_inputs(input int n);
    run    = ($urandom_range(0, 7) != 0);
    enable = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 63) == 0) dir = ~dir;
    if ($urandom_range(0, 19) == 0) freeze = ~freeze;
    if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) clr[i] = (n > 1500) && ($urandom_range(0, 39) == 0);
    rst = (n > 3000) && ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    p = 0; fd = 0;
    for (int k = 0; k < 2; k++) begin
      m_lamps[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0; m_snap[k][i] = 0; m_wrap[k][i] = 0;
      end
    end
    rst = 1'b1; run = 1'b0; dir = 1'b1; enable = 1'b0; freeze = 1'b0;
    clr = '0; sel = '0;
    repeat (2) step();
    check_eq("reset_lamps", 32'(lamps4), 0);
    check_eq("reset_wrap",  32'(wrap4),  0);

    // Directed start: channel 0 counts every 4 clocks, first visible at cycle 4.
    rst = 1'b0; run = 1'b1; dir = 1'b1; enable = 1'b1; sel = 2'd0;
    for (int c = 1; c <= 64; c++) begin
      step();
      if (c == 4)  check_eq("first_tick",  32'(lamps4), 1);
      if (c == 8)  check_eq("second_tick", 32'(lamps4), 2);
      if (c == 63) check_eq("wrap0_pulse", 32'(wrap4[0]), 1);
      if (c == 64) check_eq("wrap0_clear", 32'(wrap4[0]), 0);
    end

    for (int n = 0; n < 6000; n++) begin
      randomize_inputs(n);
      step();
    end

    // Out-of-range sel on the 3-channel instance, then reset while frozen.
    rst = 1'b0; run = 1'b1; enable = 1'b1; freeze = 1'b1; clr = '0; sel = 2'd3;
    repeat (10) step();
    check_eq("sel_oob", 32'(lamps3), 0);
    rst = 1'b1;
    step();
    check_eq("rst_frozen_lamps", 32'(lamps4), 0);
    check_eq("rst_frozen_wrap",  32'(wrap4),  0);
    rst = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
